ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline register plus ALU-control decoder and operand-forwarding unit for the rv32i core. It captures decoded instruction fields at the end of Decode and resolves RAW hazards from the Memory and Writeback stages. It drives SrcA, SrcB and the 4-bit ALUControl of the alu in Execute. It also drives the store data and destination bookkeeping onward to EX/MEM.

Parameters:
XLEN, 32, datapath width
REGW, 5, register-index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ValidD  in  1  Decode slot holds a real instruction
StallE  in  1  hold E-stage registers
FlushE  in  1  replace E-stage contents with a bubble
ALUOpD  in  2  00 add, 01 sub, 10 funct decode, 11 reserved
funct3D  in  3  instruction funct3
funct7b5D  in  1  instruction bit 30
op5D  in  1  opcode bit 5 (1 = R-type)
ALUSrcBD  in  1  1 selects immediate for SrcB
RegWriteD  in  1  instruction writes rd
RD1D, RD2D  in  XLEN  register-file read data
ImmExtD  in  XLEN  extended immediate
Rs1D, Rs2D, RdD  in  REGW  register indices
RdM  in  REGW  Memory-stage destination
RegWriteM  in  1  Memory-stage write enable
ALUResultM  in  XLEN  Memory-stage result
RdW  in  REGW  Writeback-stage destination
RegWriteW  in  1  Writeback-stage write enable
ResultW  in  XLEN  Writeback-stage result
SrcAE  out  XLEN  alu operand A
SrcBE  out  XLEN  alu operand B
ALUControlE  out  4  alu operation
WriteDataE  out  XLEN  forwarded rs2 value for stores
RdE  out  REGW  E-stage destination
RegWriteE  out  1  E-stage write enable, gated by valid
ValidE  out  1  E-stage holds a real instruction
IllegalE  out  1  ALU-control decode failed

Behaviour:
- ALUControl encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10-15 unused.
- The decode is combinational on the D inputs. Its result is registered into ALUControlE and IllegalE.
  - ALUOp 00 -> ADD.
  - ALUOp 01 -> SUB.
  - ALUOp 10, by funct3:
    - 000 -> SUB if op5&funct7b5, else ADD
    - 001 -> SLL
    - 010 -> SLT
    - 011 -> SLTU
    - 100 -> XOR
    - 101 -> SRA if funct7b5, else SRL
    - 110 -> OR
    - 111 -> AND
  - ALUOp 11 -> ALUControl 0 and IllegalE 1.
- Registered state: ValidE, RegWriteE, ALUSrcBE, ALUControlE, IllegalE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE.
- Reset (async, asserted): every register is 0. SrcAE, SrcBE and WriteDataE therefore read 0 while no M/W forward matches index 0. Index 0 never matches.
- Rising edge, priority order:
  - FlushE -> bubble: all registers 0.
  - else StallE -> hold.
  - else capture D.
  - FlushE with StallE: flush wins.
- RegWriteE and IllegalE are captured ANDed with ValidD, so an invalid slot never writes or traps.
- Latency: D inputs appear at the E outputs 1 cycle after capture.
- Forwarding is combinational from the E registers and the current M/W inputs. It is re-evaluated every cycle, including during a stall.
  - fwdA = ALUResultM if RegWriteM && RdM!=0 && RdM==Rs1E.
  - else fwdA = ResultW if RegWriteW && RdW!=0 && RdW==Rs1E.
  - else fwdA = RD1E.
  - fwdB is the same, using Rs2E/RD2E.
  - M has priority over W when both match.
- SrcAE = fwdA. SrcBE = ALUSrcBE ? ImmExtE : fwdB. WriteDataE = fwdB, even when the immediate is selected.
- Reset asserted mid-operation clears the stage immediately. The first capture happens on the first edge after deassertion.

Test Plan:
- Reset then release, all D inputs 0: ValidE=0, RegWriteE=0, ALUControlE=0, SrcAE=SrcBE=0.
- ALUOpD=10, funct3=101, funct7b5=1, ValidD=1, one edge: ALUControlE=9. Then funct7b5=0: ALUControlE=8. Then funct3=000, op5=1, funct7b5=1: ALUControlE=1. Then op5=0: ALUControlE=0.
- Forwarding setup: RD1D=0x11, Rs1D=5, captured; then RdM=5, RegWriteM=1, ALUResultM=0xAA, RdW=5, RegWriteW=1, ResultW=0xBB.
  - SrcAE=0xAA.
  - Drop RegWriteM: SrcAE=0xBB.
  - Set RdW=0 with RegWriteM=0: SrcAE=0x11.
  - Rs1D=0 captured with RdM=0, RegWriteM=1: SrcAE=RD1E.
- Store operands: ALUSrcBD=1, ImmExtD=0x4, RD2D=0x22, Rs2D=7, RdM=7, RegWriteM=1, ALUResultM=0x99: SrcBE=0x4, WriteDataE=0x99.
- Stall/flush: capture instruction A, then StallE=1 for 2 cycles while D changes to B: E outputs stay A. StallE=1 with FlushE=1: next edge ValidE=0, RegWriteE=0. ValidD=0 with RegWriteD=1, ALUOpD=11: RegWriteE=0, IllegalE=0.
- Async reset pulse between edges while ValidE=1: ValidE and RegWriteE drop to 0 before the next clock edge.

Source files
------------

// File: rtl/ex_operand_if.sv
// Bundle of signals between Decode, the ID/EX stage, the M/W bypass sources and Execute.
// The stage consumes the D-stage fields and M/W results, and produces the E-stage operands.
interface ex_operand_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  // Decode-side fields captured into the E stage
  logic            ValidD;
  logic            StallE;
  logic            FlushE;
  logic [1:0]      ALUOpD;
  logic [2:0]      funct3D;
  logic            funct7b5D;
  logic            op5D;
  logic            ALUSrcBD;
  logic            RegWriteD;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] ImmExtD;
  logic [REGW-1:0] Rs1D;
  logic [REGW-1:0] Rs2D;
  logic [REGW-1:0] RdD;

  // Bypass sources from later stages
  logic [REGW-1:0] RdM;
  logic            RegWriteM;
  logic [XLEN-1:0] ALUResultM;
  logic [REGW-1:0] RdW;
  logic            RegWriteW;
  logic [XLEN-1:0] ResultW;

  // Execute-stage results
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic [3:0]      ALUControlE;
  logic [XLEN-1:0] WriteDataE;
  logic [REGW-1:0] RdE;
  logic            RegWriteE;
  logic            ValidE;
  logic            IllegalE;

  modport master (
    output ValidD, StallE, FlushE, ALUOpD, funct3D, funct7b5D, op5D, ALUSrcBD,
           RegWriteD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           RdM, RegWriteM, ALUResultM, RdW, RegWriteW, ResultW,
    input  SrcAE, SrcBE, ALUControlE, WriteDataE, RdE, RegWriteE, ValidE, IllegalE
  );

  modport slave (
    input  ValidD, StallE, FlushE, ALUOpD, funct3D, funct7b5D, op5D, ALUSrcBD,
           RegWriteD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           RdM, RegWriteM, ALUResultM, RdW, RegWriteW, ResultW,
    output SrcAE, SrcBE, ALUControlE, WriteDataE, RdE, RegWriteE, ValidE, IllegalE
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU-control decode and M/W operand forwarding.
// Flush beats stall; forwarding is recomputed every cycle from the held E fields.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic           clk,
  input  logic           reset,
  ex_operand_if.slave    bus
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  logic [3:0]      alu_control_next;
  logic            illegal_next;

  logic            valid_reg;
  logic            reg_write_reg;
  logic            alu_src_b_reg;
  logic [3:0]      alu_control_reg;
  logic            illegal_reg;
  logic [XLEN-1:0] rd1_reg;
  logic [XLEN-1:0] rd2_reg;
  logic [XLEN-1:0] imm_ext_reg;
  logic [REGW-1:0] rs1_reg;
  logic [REGW-1:0] rs2_reg;
  logic [REGW-1:0] rd_reg;

  logic [REGW-1:0] rs_sel   [2];
  logic [XLEN-1:0] rdata_sel[2];
  logic [XLEN-1:0] fwd      [2];
  logic            hit_m    [2];
  logic            hit_w    [2];

  // ALU-control decode on the Decode-stage fields
  always_comb begin
    alu_control_next = ALU_ADD;
    illegal_next     = 1'b0;
    unique case (bus.ALUOpD)
      2'b00: alu_control_next = ALU_ADD;
      2'b01: alu_control_next = ALU_SUB;
      2'b10: begin
        unique case (bus.funct3D)
          3'b000: alu_control_next = (bus.op5D & bus.funct7b5D) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control_next = ALU_SLL;
          3'b010: alu_control_next = ALU_SLT;
          3'b011: alu_control_next = ALU_SLTU;
          3'b100: alu_control_next = ALU_XOR;
          3'b101: alu_control_next = bus.funct7b5D ? ALU_SRA : ALU_SRL;
          3'b110: alu_control_next = ALU_OR;
          3'b111: alu_control_next = ALU_AND;
          default: alu_control_next = ALU_ADD;
        endcase
      end
      default: begin
        alu_control_next = ALU_ADD;
        illegal_next     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg       <= 1'b0;
      reg_write_reg   <= 1'b0;
      alu_src_b_reg   <= 1'b0;
      alu_control_reg <= 4'd0;
      illegal_reg     <= 1'b0;
      rd1_reg         <= '0;
      rd2_reg         <= '0;
      imm_ext_reg     <= '0;
      rs1_reg         <= '0;
      rs2_reg         <= '0;
      rd_reg          <= '0;
    end else if (bus.FlushE) begin
      valid_reg       <= 1'b0;
      reg_write_reg   <= 1'b0;
      alu_src_b_reg   <= 1'b0;
      alu_control_reg <= 4'd0;
      illegal_reg     <= 1'b0;
      rd1_reg         <= '0;
      rd2_reg         <= '0;
      imm_ext_reg     <= '0;
      rs1_reg         <= '0;
      rs2_reg         <= '0;
      rd_reg          <= '0;
    end else if (!bus.StallE) begin
      // An invalid slot must never write back or raise a trap downstream
      valid_reg       <= bus.ValidD;
      reg_write_reg   <= bus.RegWriteD & bus.ValidD;
      alu_src_b_reg   <= bus.ALUSrcBD;
      alu_control_reg <= alu_control_next;
      illegal_reg     <= illegal_next & bus.ValidD;
      rd1_reg         <= bus.RD1D;
      rd2_reg         <= bus.RD2D;
      imm_ext_reg     <= bus.ImmExtD;
      rs1_reg         <= bus.Rs1D;
      rs2_reg         <= bus.Rs2D;
      rd_reg          <= bus.RdD;
    end
  end

  assign rs_sel[0]    = rs1_reg;
  assign rs_sel[1]    = rs2_reg;
  assign rdata_sel[0] = rd1_reg;
  assign rdata_sel[1] = rd2_reg;

  // Memory stage is younger than Writeback, so its result wins when both match
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign hit_m[gi] = bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == rs_sel[gi]);
      assign hit_w[gi] = bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == rs_sel[gi]);
      assign fwd[gi]   = hit_m[gi] ? bus.ALUResultM :
                         hit_w[gi] ? bus.ResultW    : rdata_sel[gi];
    end
  endgenerate

  assign bus.SrcAE       = fwd[0];
  assign bus.SrcBE       = alu_src_b_reg ? imm_ext_reg : fwd[1];
  assign bus.WriteDataE  = fwd[1];
  assign bus.ALUControlE = alu_control_reg;
  assign bus.IllegalE    = illegal_reg;
  assign bus.RdE         = rd_reg;
  assign bus.RegWriteE   = reg_write_reg;
  assign bus.ValidE      = valid_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam int SEL_VALID = 0;
  localparam int SEL_REGWR = 1;
  localparam int SEL_ALUCTL = 2;
  localparam int SEL_ILLEGAL = 3;
  localparam int SEL_SRCA = 4;
  localparam int SEL_SRCB = 5;
  localparam int SEL_WDATA = 6;
  localparam int SEL_RDE = 7;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  string       name_q[$];
  int          sel_q[$];
  logic [31:0] val_q[$];
  int          cyc_q[$];

  ex_operand_if #(.XLEN(32), .REGW(5)) bus ();

  ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual_of(int sel);
    case (sel)
      SEL_VALID:   return {31'd0, bus.ValidE};
      SEL_REGWR:   return {31'd0, bus.RegWriteE};
      SEL_ALUCTL:  return {28'd0, bus.ALUControlE};
      SEL_ILLEGAL: return {31'd0, bus.IllegalE};
      SEL_SRCA:    return bus.SrcAE;
      SEL_SRCB:    return bus.SrcBE;
      SEL_WDATA:   return bus.WriteDataE;
      default:     return {27'd0, bus.RdE};
    endcase
  endfunction

  always @(negedge clk) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      string       n;
      int          s;
      logic [31:0] v;
      int          c;
      logic [31:0] a;
      n = name_q.pop_front();
      s = sel_q.pop_front();
      v = val_q.pop_front();
      c = cyc_q.pop_front();
      a = actual_of(s);
      checks++;
      if (c != cyc || a !== v) begin
        errors++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h (due cycle %0d, sampled cycle %0d)",
                 n, a, v, c, cyc);
      end else begin
        $display("ok   %s: 0x%08h (cycle %0d)", n, a, cyc);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] val);
    name_q.push_back(name);
    sel_q.push_back(sel);
    val_q.push_back(val);
    cyc_q.push_back(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ValidD = 0; bus.StallE = 0; bus.FlushE = 0; bus.ALUOpD = 2'b00;
    bus.funct3D = 3'b000; bus.funct7b5D = 0; bus.op5D = 0; bus.ALUSrcBD = 0;
    bus.RegWriteD = 0; bus.RD1D = '0; bus.RD2D = '0; bus.ImmExtD = '0;
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
    bus.RdM = '0; bus.RegWriteM = 0; bus.ALUResultM = '0;
    bus.RdW = '0; bus.RegWriteW = 0; bus.ResultW = '0;
  endtask

  task automatic clear_bypass();
    bus.RdM = '0; bus.RegWriteM = 0; bus.ALUResultM = '0;
    bus.RdW = '0; bus.RegWriteW = 0; bus.ResultW = '0;
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1;
    clear_inputs();
    repeat (2) step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ValidE !== 1'b0 || bus.SrcAE !== 32'h0) begin
      errors++;
      $display("FAIL direct_reset: ValidE=%b SrcAE=0x%08h, expected 0 and 0x00000000",
               bus.ValidE, bus.SrcAE);
    end else begin
      $display("ok   direct_reset: ValidE=%b SrcAE=0x%08h", bus.ValidE, bus.SrcAE);
    end

    expect_val("reset_valid", SEL_VALID, 0);
    expect_val("reset_regwr", SEL_REGWR, 0);
    expect_val("reset_aluctl", SEL_ALUCTL, 0);
    expect_val("reset_srca", SEL_SRCA, 0);
    expect_val("reset_srcb", SEL_SRCB, 0);

    bus.ValidD = 1; bus.RegWriteD = 1; bus.ALUOpD = 2'b10;
    bus.funct3D = 3'b101; bus.funct7b5D = 1;
    step();
    checks++;
    if (bus.ALUControlE !== 4'd9) begin
      errors++;
      $display("FAIL direct_dec_sra: got %0d, expected 9", bus.ALUControlE);
    end else begin
      $display("ok   direct_dec_sra: %0d", bus.ALUControlE);
    end
    expect_val("dec_sra", SEL_ALUCTL, 9);
    expect_val("dec_valid", SEL_VALID, 1);
    expect_val("dec_regwr", SEL_REGWR, 1);
    bus.funct7b5D = 0;
    step();
    expect_val("dec_srl", SEL_ALUCTL, 8);
    bus.funct3D = 3'b000; bus.op5D = 1; bus.funct7b5D = 1;
    step();
    expect_val("dec_sub_r", SEL_ALUCTL, 1);
    bus.op5D = 0;
    step();
    expect_val("dec_addi", SEL_ALUCTL, 0);
    bus.funct3D = 3'b011;
    step();
    expect_val("dec_sltu", SEL_ALUCTL, 6);
    bus.funct3D = 3'b111;
    step();
    expect_val("dec_and", SEL_ALUCTL, 2);
    bus.ALUOpD = 2'b01;
    step();
    expect_val("dec_op01_sub", SEL_ALUCTL, 1);
    bus.ALUOpD = 2'b11;
    step();
    expect_val("dec_op11_ctl", SEL_ALUCTL, 0);
    expect_val("dec_op11_illegal", SEL_ILLEGAL, 1);

    bus.ALUOpD = 2'b00; bus.RD1D = 32'h11; bus.Rs1D = 5;
    step();
    expect_val("fwd_none", SEL_SRCA, 32'h11);
    expect_val("fwd_illegal_clear", SEL_ILLEGAL, 0);
    step();
    bus.RdM = 5; bus.RegWriteM = 1; bus.ALUResultM = 32'hAA;
    bus.RdW = 5; bus.RegWriteW = 1; bus.ResultW = 32'hBB;
    expect_val("fwd_m_over_w", SEL_SRCA, 32'hAA);
    step();
    bus.RegWriteM = 0;
    expect_val("fwd_w", SEL_SRCA, 32'hBB);
    step();
    bus.RdW = 0;
    expect_val("fwd_rdw_zero", SEL_SRCA, 32'h11);
    bus.Rs1D = 0; bus.RD1D = 32'h33;
    step();
    bus.RdM = 0; bus.RegWriteM = 1; bus.ALUResultM = 32'hAA;
    bus.RdW = 0; bus.RegWriteW = 1; bus.ResultW = 32'hBB;
    expect_val("fwd_x0_never", SEL_SRCA, 32'h33);

    clear_bypass();
    bus.ALUSrcBD = 1; bus.ImmExtD = 32'h4; bus.RD2D = 32'h22; bus.Rs2D = 7;
    step();
    bus.RdM = 7; bus.RegWriteM = 1; bus.ALUResultM = 32'h99;
    expect_val("st_srcb_imm", SEL_SRCB, 32'h4);
    expect_val("st_wdata_m", SEL_WDATA, 32'h99);
    step();
    bus.RegWriteM = 0; bus.RdW = 7; bus.RegWriteW = 1; bus.ResultW = 32'h55;
    expect_val("st_wdata_w", SEL_WDATA, 32'h55);
    step();
    clear_bypass();
    expect_val("st_wdata_rf", SEL_WDATA, 32'h22);
    bus.ALUSrcBD = 0;
    step();
    expect_val("st_srcb_reg", SEL_SRCB, 32'h22);

    bus.ValidD = 1; bus.RegWriteD = 1; bus.ALUOpD = 2'b01; bus.RdD = 9;
    bus.RD1D = 32'h100; bus.Rs1D = 3; bus.RD2D = 32'h200; bus.Rs2D = 4;
    step();
    expect_val("a_aluctl", SEL_ALUCTL, 1);
    expect_val("a_rde", SEL_RDE, 9);
    bus.StallE = 1; bus.ALUOpD = 2'b00; bus.RdD = 12; bus.RD1D = 32'h300; bus.Rs1D = 6;
    step();
    expect_val("stall1_aluctl", SEL_ALUCTL, 1);
    expect_val("stall1_rde", SEL_RDE, 9);
    expect_val("stall1_srca", SEL_SRCA, 32'h100);
    step();
    bus.RdM = 3; bus.RegWriteM = 1; bus.ALUResultM = 32'h777;
    expect_val("stall2_rde", SEL_RDE, 9);
    expect_val("stall2_fwd_srca", SEL_SRCA, 32'h777);
    bus.FlushE = 1;
    step();
    clear_bypass();
    expect_val("flush_valid", SEL_VALID, 0);
    expect_val("flush_regwr", SEL_REGWR, 0);
    expect_val("flush_rde", SEL_RDE, 0);
    expect_val("flush_srca", SEL_SRCA, 0);

    bus.FlushE = 0; bus.StallE = 0;
    bus.ValidD = 0; bus.RegWriteD = 1; bus.ALUOpD = 2'b11;
    step();
    expect_val("inv_regwr", SEL_REGWR, 0);
    expect_val("inv_illegal", SEL_ILLEGAL, 0);
    expect_val("inv_valid", SEL_VALID, 0);

    bus.ValidD = 1; bus.RegWriteD = 1; bus.ALUOpD = 2'b00;
    step();
    expect_val("pre_rst_valid", SEL_VALID, 1);
    expect_val("pre_rst_regwr", SEL_REGWR, 1);
    step();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0) begin
      errors++;
      $display("FAIL direct_async_rst: ValidE=%b RegWriteE=%b, expected 0 0",
               bus.ValidE, bus.RegWriteE);
    end else begin
      $display("ok   direct_async_rst: ValidE=%b RegWriteE=%b", bus.ValidE, bus.RegWriteE);
    end
    expect_val("async_rst_valid", SEL_VALID, 0);
    expect_val("async_rst_regwr", SEL_REGWR, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    step();
    expect_val("post_rst_valid", SEL_VALID, 1);

    for (int i = 0; i < 5 && cyc_q.size() > 0; i++) @(negedge clk);
    #1;
    while (cyc_q.size() > 0) begin
      string n;
      n = name_q.pop_front();
      void'(sel_q.pop_front());
      void'(val_q.pop_front());
      void'(cyc_q.pop_front());
      checks++;
      errors++;
      $display("FAIL %s: got no sample, expected a comparison before timeout", n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
